serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, meaning the reset; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning the operand request is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept an operand request.
REQ-006 SHALL have port A, input, WIDTH, meaning the first operand.
REQ-007 SHALL have port B, input, WIDTH, meaning the second operand.
REQ-008 SHALL have port SUB, input, 1, meaning 0 selects A+B and 1 selects A-B.
REQ-009 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 SHALL have port S, output, WIDTH, meaning the result word.
REQ-012 SHALL have port CO, output, 1, meaning the carry out of the MSB (1 = no borrow when SUB=1).
REQ-013 SHALL have port OVF, output, 1, meaning two's-complement signed overflow.

Function
REQ-014 SHALL compute through exactly one full_adder instance, time-shared bit-serially, LSB first; no WIDTH-wide adder.
REQ-015 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-016 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL accept on an edge with in_valid&in_ready: latch A, B^{WIDTH{SUB}}, carry register <= SUB, bit counter <= 0, go to RUN.
REQ-018 SHALL in RUN, per edge: feed operand LSBs and carry register to full_adder, shift Sum into S from MSB side, store Carry, increment counter.
REQ-019 SHALL leave RUN for DONE on the edge processing bit WIDTH-1; out_valid is high exactly WIDTH cycles after the accept edge.
REQ-020 SHALL in DONE set CO = final carry and OVF = carry into MSB XOR carry out of MSB, captured on the last RUN edge.
REQ-021 SHALL hold S, CO, OVF, out_valid stable in DONE while out_ready=0.
REQ-022 SHALL return to IDLE on the edge where out_valid&out_ready; S/CO/OVF keep last values in IDLE.
REQ-023 SHALL ignore in_valid, A, B, SUB outside IDLE; operands changing during RUN do not affect result.
REQ-024 SHALL allow a new accept on the first IDLE cycle after a result handshake (throughput one op per WIDTH+2 cycles minimum).
REQ-025 SHALL wrap results modulo 2^WIDTH; no saturation.

Reset
REQ-026 SHALL on rst=1, immediately and regardless of state: state=IDLE, in_ready=1, out_valid=0, S=0, CO=0, OVF=0, counter=0, carry register=0.
REQ-027 SHALL abandon any in-progress operation on reset mid-RUN or mid-DONE; no out_valid produced for it.

Verification (WIDTH=8)
REQ-028 SHALL cover add 0xFF+0x01, SUB=0 -> S=0x00, CO=1, OVF=0, out_valid 8 cycles after accept.
REQ-029 SHALL cover add 0x7F+0x01, SUB=0 -> S=0x80, CO=0, OVF=1.
REQ-030 SHALL cover sub 0x05-0x07, SUB=1 -> S=0xFE, CO=0, OVF=0; and 0x80-0x01 -> S=0x7F, CO=1, OVF=1.
REQ-031 SHALL cover out_ready held 0 for 5 cycles in DONE -> S/CO/OVF/out_valid unchanged, in_ready=0, in_valid pulses ignored.
REQ-032 SHALL cover rst asserted at RUN bit 3 of 0x12+0x34 -> all outputs 0, in_ready=1 next cycle; following 0x12+0x34 -> S=0x46, CO=0.
REQ-033 SHALL cover back-to-back ops with out_ready=1, in_valid=1 constantly -> each op accepted on first IDLE cycle, results in order.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract unit with valid/ready handshakes on both sides.
// One full adder is reused per cycle, LSB first, over WIDTH cycles.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid / in_ready  operand request handshake (ready only in IDLE)
//   A, B, SUB            operands; SUB=1 selects A-B
//   out_valid/out_ready  result handshake (valid only in DONE)
//   S, CO, OVF           result word, carry out of MSB, signed overflow

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;
  logic last_bit;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B, seed carry with 1.
          a_d     = A;
          b_d     = B ^ {WIDTH{SUB}};
          c_d     = SUB;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum enters at the MSB; after WIDTH shifts bit 0 is in place.
        s_d   = {fa_sum, s_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_cout;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // c_q is the carry into the MSB on this step.
          co_d    = fa_cout;
          ovf_d   = c_q ^ fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign CO        = co_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
// Vector table plus stall, reset-abort and back-to-back sequences.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         SUB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         CO;
  logic         OVF;

  int total;
  int bad;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .CO        (CO),
    .OVF       (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation; operands are scrambled while in RUN.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    A = v.a;
    B = v.b;
    SUB = v.sub;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      A = W'($urandom);
      B = W'($urandom);
      SUB = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_S"}, 32'(S), 32'(v.s));
    chk({tag, "_CO"}, 32'(CO), 32'(v.co));
    chk({tag, "_OVF"}, 32'(OVF), 32'(v.ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  vec_t ops[4];
  int   nacc;
  int   nres;
  int   last_acc;
  int   cyc;

  initial begin
    total = 0;
    bad = 0;
    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vt[5] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
    vt[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[7] = '{8'h3C, 8'h0F, 1'b1, 8'h2D, 1'b1, 1'b0};
    vt[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    SUB = 1'b0;
    #12;
    chk("reset_state", {20'd0, in_ready, out_valid, S, CO, OVF},
        {20'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i], $sformatf("vec%0d", i));
    end

    // Reset during RUN bit 3 of 0x12+0x34 (CO/OVF still 1 from last op).
    @(negedge clk);
    A = 8'h12;
    B = 8'h34;
    SUB = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_run_outs", {20'd0, in_ready, out_valid, S, CO, OVF},
        {20'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_next", 32'(in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("rst_no_out_valid", 32'(seen), 32'd0);
    end
    run_op(vt[4], "after_rst");

    // Stall in DONE with in_valid pulses that must be ignored.
    @(negedge clk);
    A = 8'hA5;
    B = 8'h5A;
    SUB = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    begin
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("stall_latency", 32'(lat), 32'd8);
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      A = 8'h01;
      B = 8'h01;
      SUB = 1'b1;
      @(negedge clk);
      chk($sformatf("stall_hold%0d", k),
          {20'd0, in_ready, out_valid, S, CO, OVF},
          {20'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_keeps_S", {22'd0, in_ready, out_valid, S},
        {22'd0, 1'b1, 1'b0, 8'hFF});

    // Back-to-back with in_valid and out_ready held high.
    ops[0] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    ops[1] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0};
    ops[2] = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0};
    ops[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    nacc = 0;
    nres = 0;
    last_acc = 0;
    cyc = 0;
    A = ops[0].a;
    B = ops[0].b;
    SUB = ops[0].sub;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (nres < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk($sformatf("b2b_res%0d", nres), {23'd0, S, CO},
            {23'd0, ops[nres].s, ops[nres].co});
        nres++;
      end
      if (in_ready && nacc < 3) begin
        if (nacc > 0) begin
          chk($sformatf("b2b_gap%0d", nacc), 32'(cyc - last_acc), 32'd10);
        end
        last_acc = cyc;
        nacc++;
        A = ops[nacc].a;
        B = ops[nacc].b;
        SUB = ops[nacc].sub;
        if (nacc == 3) in_valid = 1'b0;
      end
    end
    chk("b2b_count", 32'(nres), 32'd3);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
